serial_bit_feeder: RTL and testbench

- Upstream stage of the 1010 sequence detector.
- Accepts parallel words over a valid/ready handshake and serialises them into the detector's single-bit `in` stream, one bit per enabled cycle.
- A one-word pending buffer allows back-to-back words with no idle gap in the serial stream.
- bit_out connects directly to the detector's `in` port; both blocks share clk.

---
 rtl/seq_pkg.sv | 8 +
 rtl/feed_pending_buf.sv | 33 +++
 rtl/serial_bit_feeder.sv | 107 ++++++++++
 tb/tb_serial_bit_feeder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial feeder and the 1010 sequence detector.
package seq_pkg;

   typedef enum logic {FEED_IDLE, FEED_SHIFT} feed_state_t;

   localparam logic [3:0] SEQ_PATTERN = 4'b1010;

endpackage

// File: rtl/feed_pending_buf.sv
// Single-entry holding register that lets the next word wait while the shifter is busy.
module feed_pending_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_unload,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;

   // Load and unload are never requested together by the feeder; load wins if they are.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_unload) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule

// File: rtl/serial_bit_feeder.sv
// Serialises parallel words into the detector's single-bit stream, one bit per bit_en cycle,
// with a one-word pending buffer so consecutive words run back to back.
module serial_bit_feeder
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic             bit_en,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             busy
);

   localparam int unsigned   CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam int unsigned   OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;

   feed_state_t      r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_cnt;
   logic             r_data_ready;

   logic             w_shift;
   logic             w_accept;
   logic             w_last;
   logic             w_load_pend;
   logic             w_unload;
   logic             w_pend_full;
   logic             w_pend_full_nxt;
   logic [WIDTH-1:0] w_pend_data;
   logic [WIDTH-1:0] w_shifted;

   assign w_shift  = (r_state == FEED_SHIFT);
   assign w_accept = data_valid & r_data_ready;
   assign w_last   = w_shift & bit_en & (r_cnt == '0);

   // A word accepted on the last-bit edge bypasses the pending slot and loads the shifter.
   assign w_load_pend     = w_accept & w_shift & ~w_last;
   assign w_unload        = w_last & w_pend_full;
   assign w_pend_full_nxt = (w_pend_full & ~w_unload) | w_load_pend;

   assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

   feed_pending_buf #(.WIDTH(WIDTH)) u_pend (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_load   (w_load_pend),
      .i_unload (w_unload),
      .i_data   (data_in),
      .o_full   (w_pend_full),
      .o_data   (w_pend_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= FEED_IDLE;
         r_shreg      <= '0;
         r_cnt        <= '0;
         r_data_ready <= 1'b0;
      end else begin
         r_data_ready <= ~w_pend_full_nxt;
         case (r_state)
            FEED_IDLE: begin
               if (w_accept) begin
                  r_shreg <= data_in;
                  r_cnt   <= CNT_LAST;
                  r_state <= FEED_SHIFT;
               end
            end
            FEED_SHIFT: begin
               if (bit_en) begin
                  if (r_cnt != '0) begin
                     r_shreg <= w_shifted;
                     r_cnt   <= r_cnt - CW'(1);
                  end else if (w_pend_full) begin
                     r_shreg <= w_pend_data;
                     r_cnt   <= CNT_LAST;
                  end else if (w_accept) begin
                     r_shreg <= data_in;
                     r_cnt   <= CNT_LAST;
                  end else begin
                     r_state <= FEED_IDLE;
                  end
               end
            end
            default: r_state <= FEED_IDLE;
         endcase
      end
   end

   assign data_ready  = r_data_ready;
   assign bit_out     = w_shift ? r_shreg[OUT_IDX] : IDLE_BIT;
   assign bit_valid   = w_shift;
   assign frame_start = w_shift & (r_cnt == CNT_LAST);
   assign frame_done  = w_last;
   assign busy        = w_shift | w_pend_full;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: one MSB-first and one LSB-first instance on a shared clock.
module tb_serial_bit_feeder;
   import seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid, a_en, b_en;
   logic       a_ready, a_bit_out, a_bit_valid, a_frame_start, a_frame_done, a_busy;
   logic       b_ready, b_bit_out, b_bit_valid, b_frame_start, b_frame_done, b_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk(clk), .reset_n(reset_n), .data_in(a_data), .data_valid(a_valid),
      .data_ready(a_ready), .bit_en(a_en), .bit_out(a_bit_out), .bit_valid(a_bit_valid),
      .frame_start(a_frame_start), .frame_done(a_frame_done), .busy(a_busy)
   );

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .reset_n(reset_n), .data_in(b_data), .data_valid(b_valid),
      .data_ready(b_ready), .bit_en(b_en), .bit_out(b_bit_out), .bit_valid(b_bit_valid),
      .frame_start(b_frame_start), .frame_done(b_frame_done), .busy(b_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0]  w, wb;
      logic [3:0]  nib;
      logic [7:0]  words [3];
      logic [23:0] got;
      int          nbits, idx, first_done, acc2;

      reset_n = 1'b0;
      a_data = 8'h00; a_valid = 1'b0; a_en = 1'b0;
      b_data = 8'h00; b_valid = 1'b0; b_en = 1'b0;
      nib = 4'h0;

      // reset state
      tick(); tick();
      chk("rst_ready", a_ready, 1'b0);
      chk("rst_bit_out", a_bit_out, 1'b0);
      chk("rst_bit_valid", a_bit_valid, 1'b0);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_start", a_frame_start, 1'b0);
      chk("rst_done", a_frame_done, 1'b0);
      reset_n = 1'b1;
      #1;
      chk("ready_before_edge", a_ready, 1'b0);
      tick();
      chk("ready_after_edge", a_ready, 1'b1);
      chk("lsb_ready_after_edge", b_ready, 1'b1);

      // single word on both instances
      a_data = 8'hA0; a_valid = 1'b1; a_en = 1'b1;
      b_data = 8'h05; b_valid = 1'b1; b_en = 1'b1;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      w = 8'hA0; wb = 8'h05;
      for (int k = 0; k < 8; k++) begin
         chk("a0_bit", a_bit_out, w[3'(7 - k)]);
         chk("a0_valid", a_bit_valid, 1'b1);
         chk("a0_start", a_frame_start, k == 0);
         chk("a0_done", a_frame_done, k == 7);
         chk("lsb05_bit", b_bit_out, wb[3'(k)]);
         chk("lsb05_done", b_frame_done, k == 7);
         if (k < 4) nib = {nib[2:0], a_bit_out};
         tick();
      end
      chkw("seq_window", 32'(nib), 32'(SEQ_PATTERN));
      chk("a0_idle_valid", a_bit_valid, 1'b0);
      chk("a0_idle_busy", a_busy, 1'b0);
      chk("lsb_idle_valid", b_bit_valid, 1'b0);

      // back-to-back AA then 55
      a_data = 8'hAA; a_valid = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         w = (i < 8) ? 8'hAA : 8'h55;
         if (i == 0) a_data = 8'h55;
         if (i == 1) a_valid = 1'b0;
         chk("b2b_bit", a_bit_out, w[3'(7 - (i % 8))]);
         chk("b2b_valid", a_bit_valid, 1'b1);
         chk("b2b_start", a_frame_start, (i == 0) || (i == 8));
         chk("b2b_done", a_frame_done, (i == 7) || (i == 15));
         chk("b2b_ready", a_ready, !((i >= 1) && (i <= 7)));
         tick();
      end
      chk("b2b_idle", a_bit_valid, 1'b0);

      // throttled F0, bit_en 0,1,0,1...
      a_data = 8'hF0; a_valid = 1'b1; a_en = 1'b1;
      tick();
      a_valid = 1'b0;
      w = 8'hF0;
      for (int j = 0; j < 16; j++) begin
         a_en = (j % 2) == 1;
         #1;
         chk("thr_bit", a_bit_out, w[3'(7 - j / 2)]);
         chk("thr_valid", a_bit_valid, 1'b1);
         chk("thr_done", a_frame_done, j == 15);
         tick();
      end
      chk("thr_idle", a_bit_valid, 1'b0);
      a_en = 1'b1;

      // three words offered as fast as the handshake allows
      words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h96;
      got = '0; nbits = 0; idx = 0; first_done = -1; acc2 = -1;
      for (int c = 0; c < 40; c++) begin
         if (a_bit_valid) begin
            got = {got[22:0], a_bit_out};
            nbits++;
         end
         if (a_frame_done && first_done < 0) first_done = c;
         if (idx < 3) begin
            a_valid = 1'b1;
            a_data  = words[idx];
         end else begin
            a_valid = 1'b0;
         end
         if (a_valid && a_ready) begin
            if (idx == 2) acc2 = c;
            idx++;
         end
         tick();
      end
      a_valid = 1'b0;
      chkw("pend_bits", 32'(nbits), 32'd24);
      chkw("pend_stream", 32'(got), 32'h3CC396);
      chkw("pend_first_done", 32'(first_done), 32'd8);
      chkw("pend_acc3", 32'(acc2), 32'd9);
      chk("pend_idle_busy", a_busy, 1'b0);

      // reset in the middle of FF, then 0A from a clean start
      a_data = 8'hFF; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick(); tick(); tick();
      chk("mid_bit4", a_bit_out, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_bit", a_bit_out, 1'b0);
      chk("mid_rst_valid", a_bit_valid, 1'b0);
      chk("mid_rst_busy", a_busy, 1'b0);
      chk("mid_rst_ready", a_ready, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("mid_ready_back", a_ready, 1'b1);
      a_data = 8'h0A; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      w = 8'h0A;
      for (int k = 0; k < 8; k++) begin
         chk("post_bit", a_bit_out, w[3'(7 - k)]);
         chk("post_start", a_frame_start, k == 0);
         tick();
      end
      chk("post_idle", a_bit_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
